enc_instr: RTL and testbench
============================

Name: enc_instr

Overview:
- Streaming RV32 instruction encoder; the inverse of the core's opcode decoder.
- Accepts field-level instruction requests (class, funct3, funct7, rd, rs1, rs2, imm) over a valid/ready handshake and packs each into a 32-bit machine word.
- Writes the words sequentially into instruction memory from a base address; expands the LI pseudo-op into LUI+ADDI.
- Sits between the test/boot loader front end and the imem write port.

Parameters:
- ADDR_W, 10, imem word-address width.
- BASE_ADDR, 0, first word address written after reset or start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse; restarts the program at BASE_ADDR and clears errors.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_class  in  4  enc_pkg class: LW, SW, R, B, I, JAL, AUIPC, LUI, JALR, F, LI.
- in_fun3  in  3  funct3.
- in_fun7  in  7  funct7.
- in_rd / in_rs1 / in_rs2  in  5 each  register indices.
- in_imm  in  32  signed byte immediate; U-class carries the 20-bit upper value in imm[19:0].
- in_last  in  1  marks the final request of the program.
- out_we  out  1  imem write strobe.
- out_addr  out  ADDR_W  imem word address.
- out_data  out  32  encoded instruction.
- done  out  1  program complete; stays high until start or reset.
- err  out  1  sticky error.
- err_code  out  2  first error cause: 0 RANGE, 1 ALIGN, 2 OVERFLOW, 3 CLASS.
- err_addr  out  ADDR_W  address where the first error occurred.

Behaviour:
- Reset (rst_n=0 at clk edge, any state): state=IDLE; in_ready=0 during reset; out_we=0; out_addr=BASE_ADDR; out_data=0; done=0; err=0; err_code=0; err_addr=0; write pointer=BASE_ADDR.
- States:
  - IDLE: in_ready=1.
  - LI2: in_ready=0; emits the second word of LI.
  - DONE: in_ready=0.
- Latency: request accepted at edge N; out_we pulses for exactly one cycle after edge N+1, with out_addr=pointer and out_data=word. Pointer increments after each write.
- Sustained throughput: one word per cycle in IDLE.
- Opcodes:
  - LW 0000011, SW 0100011, R 0110011, B 1100011, I 0010011.
  - JAL 1101111, AUIPC 0010111, LUI 0110111, JALR 1100111, F 1010011.
- Formats:
  - I: LW, I, JALR.
  - S: SW.
  - B: B.
  - U: LUI, AUIPC.
  - J: JAL.
  - R: R, F. The full funct7 is placed in [31:25].
- I-class shifts (fun3=001/101): imm must be 0..31; word[24:20]=imm[4:0]; word[31:25]=in_fun7, so 0100000 gives SRAI.
- Range checks:
  - I/S: imm in -2048..2047.
  - B: imm in -4096..4094.
  - JAL: imm in -1048576..1048574.
  - Violation -> RANGE.
  - B/JAL with odd imm -> ALIGN; ALIGN takes priority over RANGE.
  - Unknown class -> CLASS.
- Error handling: an erroneous request is consumed but not written, and the pointer is unchanged. err is set and err_code/err_addr latch only on the first error. Encoding continues afterwards.
- LI:
  - If imm is in -2048..2047: a single ADDI rd,x0,imm.
  - Otherwise: LUI rd,(imm+0x800)>>12 in the first cycle, then state LI2 and ADDI rd,rd,imm[11:0] in the next cycle.
- in_last: after the final word of that request is written (the ADDI for a two-word LI), go to DONE and assert done the following cycle. An erroneous last request also goes to DONE.
- Overflow: a word needing a write when the pointer has already wrapped past 2^ADDR_W-1 is not written; err_code=OVERFLOW; go to DONE. The last legal address is still written.
- start: highest priority after reset. Clears the pointer and errors, returns to IDLE, and drops any pending LI2 word. in_ready=0 in the start cycle, so a simultaneous in_valid is not accepted.

Optional Feature:
- Macro: ENC_INSTR_CHECKSUM_EN.
- Defined: adds output checksum[31:0], a running 32-bit wrap-around sum of every word written. Cleared by reset and start; updated in the same cycle as out_we.
- Undefined: no port and no logic.

Decomposition:
- enc_pkg holds:
  - the class enum;
  - opcode localparams;
  - the err_code enum;
  - immediate-range constants.
- One combinational sub-module, enc_instr_pack: class + fields in -> word, err_valid, err_code out; also splits LI into its hi/lo words.
- FSM, pointer and error registers stay in enc_instr.

Test Plan:
- ADDI: I, fun3=000, rd=1, rs1=0, imm=5 -> next cycle out_we=1, addr 0, data 0x00500093.
- LW then SUB:
  - LW rd=2, rs1=1, imm=8 -> 0x0080A103 at addr 0.
  - R fun3=000, fun7=0100000, rd=3, rs1=1, rs2=2 -> 0x402081B3 at addr 1, back-to-back.
- LI x5,0x12345FFF -> 0x123462B7 at addr 0, then 0xFFF28293 at addr 1; in_ready=0 for one cycle in between.
- B with imm=3 -> no write; err=1, err_code=ALIGN, err_addr=0. A following valid ADDI is still written at addr 0.
- ADDR_W=2, five ADDIs -> addrs 0..3 written; fifth gives OVERFLOW, done=1. start then resets to addr 0 with err=0.
- start and in_valid in the same cycle -> request not accepted, out_we stays 0; rst_n=0 during LI2 -> second word never written.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and constants for the RV32 instruction encoder:
// request classes, error causes, base opcodes and immediate ranges.
package enc_pkg;

  typedef enum logic [3:0] {
    CLS_LW    = 4'd0,
    CLS_SW    = 4'd1,
    CLS_R     = 4'd2,
    CLS_B     = 4'd3,
    CLS_I     = 4'd4,
    CLS_JAL   = 4'd5,
    CLS_AUIPC = 4'd6,
    CLS_LUI   = 4'd7,
    CLS_JALR  = 4'd8,
    CLS_F     = 4'd9,
    CLS_LI    = 4'd10
  } enc_class_e;

  typedef enum logic [1:0] {
    ERR_RANGE    = 2'd0,
    ERR_ALIGN    = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_CLASS    = 2'd3
  } enc_err_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_F     = 7'b1010011;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [6:0] opcode_of(input logic [3:0] cls);
    case (cls)
      CLS_LW:    return OP_LW;
      CLS_SW:    return OP_SW;
      CLS_R:     return OP_R;
      CLS_B:     return OP_B;
      CLS_I:     return OP_I;
      CLS_JAL:   return OP_JAL;
      CLS_AUIPC: return OP_AUIPC;
      CLS_LUI:   return OP_LUI;
      CLS_JALR:  return OP_JALR;
      CLS_F:     return OP_F;
      default:   return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/enc_instr_pack.sv
// Combinational field packer: one request in, its machine word(s) and any
// encoding error out. LI yields either a single ADDI or a LUI/ADDI pair.
module enc_instr_pack
  import enc_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  fun3,
  input  logic [6:0]  fun7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [31:0] lo_word,
  output logic        two_words,
  output logic        err_valid,
  output enc_err_e    err_code
);

  logic signed [31:0] simm;
  logic [6:0]         op;
  logic [19:0]        lui_hi;

  always_comb begin
    simm      = imm;
    op        = opcode_of(cls);
    // Rounds the upper part so the sign-extended ADDI low half lands exactly.
    lui_hi    = imm[31:12] + {19'd0, imm[11]};
    word      = 32'd0;
    lo_word   = 32'd0;
    two_words = 1'b0;
    err_valid = 1'b0;
    err_code  = ERR_RANGE;
    case (cls)
      CLS_LW, CLS_I, CLS_JALR: begin
        if (cls == CLS_I && (fun3 == 3'b001 || fun3 == 3'b101)) begin
          word      = {fun7, imm[4:0], rs1, fun3, rd, op};
          err_valid = !in_range(simm, 0, 31);
        end else begin
          word      = {imm[11:0], rs1, fun3, rd, op};
          err_valid = !in_range(simm, IMM12_MIN, IMM12_MAX);
        end
      end
      CLS_SW: begin
        word      = {imm[11:5], rs2, rs1, fun3, imm[4:0], op};
        err_valid = !in_range(simm, IMM12_MIN, IMM12_MAX);
      end
      CLS_B: begin
        word      = {imm[12], imm[10:5], rs2, rs1, fun3, imm[4:1], imm[11], op};
        err_valid = imm[0] || !in_range(simm, IMM13_MIN, IMM13_MAX);
        err_code  = imm[0] ? ERR_ALIGN : ERR_RANGE;
      end
      CLS_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        err_valid = imm[0] || !in_range(simm, IMM21_MIN, IMM21_MAX);
        err_code  = imm[0] ? ERR_ALIGN : ERR_RANGE;
      end
      CLS_LUI, CLS_AUIPC: word = {imm[19:0], rd, op};
      CLS_R, CLS_F:       word = {fun7, rs2, rs1, fun3, rd, op};
      CLS_LI: begin
        if (in_range(simm, IMM12_MIN, IMM12_MAX)) begin
          word = {imm[11:0], 5'd0, 3'b000, rd, OP_I};
        end else begin
          word      = {lui_hi, rd, OP_LUI};
          lo_word   = {imm[11:0], rd, 3'b000, rd, OP_I};
          two_words = 1'b1;
        end
      end
      default: begin
        err_valid = 1'b1;
        err_code  = ERR_CLASS;
      end
    endcase
  end

endmodule

// File: rtl/enc_instr.sv
// Streaming RV32 encoder: accepts field-level requests and writes packed words
// to imem from BASE_ADDR. Define ENC_INSTR_CHECKSUM_EN for a running word sum.
module enc_instr
  import enc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_fun3,
  input  logic [6:0]        in_fun7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr
`ifdef ENC_INSTR_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LI2 = 2'd1, S_DONE = 2'd2} state_e;

  // One extra pointer bit records a wrap past the last imem word.
  localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [31:0]         lo_word_q, lo_word_d;
  logic                last_q, last_d;
  logic                out_we_q, out_we_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  enc_err_e            err_code_q, err_code_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic [31:0] pk_word, pk_lo;
  logic        pk_two, pk_err;
  enc_err_e    pk_code;
  logic        fire, wr_req, wr_ok, raise;
  logic [31:0] wr_word;
  enc_err_e    raise_code;

  enc_instr_pack u_pack (
    .cls       (in_class),
    .fun3      (in_fun3),
    .fun7      (in_fun7),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .imm       (in_imm),
    .word      (pk_word),
    .lo_word   (pk_lo),
    .two_words (pk_two),
    .err_valid (pk_err),
    .err_code  (pk_code)
  );

  assign in_ready = rst_n && !start && (state_q == S_IDLE);
  assign fire     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lo_word_d  = lo_word_q;
    last_d     = last_q;
    out_we_d   = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    done_d     = (state_q == S_DONE);
    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    wr_req     = 1'b0;
    wr_ok      = 1'b0;
    wr_word    = 32'd0;
    raise      = 1'b0;
    raise_code = ERR_RANGE;
    if (start) begin
      state_d    = S_IDLE;
      ptr_d      = BASE_PTR;
      out_addr_d = BASE_PTR[ADDR_W-1:0];
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = ERR_RANGE;
      err_addr_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire && pk_err) begin
            raise      = 1'b1;
            raise_code = pk_code;
            if (in_last) state_d = S_DONE;
          end else if (fire) begin
            wr_req  = 1'b1;
            wr_word = pk_word;
            if (pk_two) begin
              state_d   = S_LI2;
              lo_word_d = pk_lo;
              last_d    = in_last;
            end else if (in_last) begin
              state_d = S_DONE;
            end
          end
        end
        S_LI2: begin
          wr_req  = 1'b1;
          wr_word = lo_word_q;
          state_d = last_q ? S_DONE : S_IDLE;
        end
        default: ;
      endcase
      if (wr_req && ptr_q[ADDR_W]) begin
        raise      = 1'b1;
        raise_code = ERR_OVERFLOW;
        state_d    = S_DONE;
      end else if (wr_req) begin
        wr_ok      = 1'b1;
        out_we_d   = 1'b1;
        out_addr_d = ptr_q[ADDR_W-1:0];
        out_data_d = wr_word;
        ptr_d      = ptr_q + PTR_ONE;
      end
      if (raise) begin
        err_d = 1'b1;
        if (!err_q) begin
          err_code_d = raise_code;
          err_addr_d = ptr_q[ADDR_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= BASE_PTR;
      lo_word_q  <= 32'd0;
      last_q     <= 1'b0;
      out_we_q   <= 1'b0;
      out_addr_q <= BASE_PTR[ADDR_W-1:0];
      out_data_q <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_RANGE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lo_word_q  <= lo_word_d;
      last_q     <= last_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign out_we   = out_we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign err_addr = err_addr_q;

`ifdef ENC_INSTR_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start)      checksum_d = 32'd0;
    else if (wr_ok) checksum_d = checksum_q + wr_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) checksum_q <= 32'd0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_enc_instr.sv
// Self-checking bench for enc_instr: directed scenarios then randomized traffic
// against a queue-based reference model built from the RV32 format rules.
module tb_enc_instr;
  import enc_pkg::*;

  localparam int AW   = 4;
  localparam int BASE = 0;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_class = '0;
  logic [2:0]    in_fun3 = '0;
  logic [6:0]    in_fun7 = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_data;
  logic          done, err;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;
`ifdef ENC_INSTR_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  enc_instr #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_fun3(in_fun3), .in_fun7(in_fun7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data), .done(done),
    .err(err), .err_code(err_code), .err_addr(err_addr)
`ifdef ENC_INSTR_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          OPS [0:10] = '{'h03, 'h23, 'h33, 'h63, 'h13, 'h6F, 'h17, 'h37, 'h67, 'h53, 0};
  int          EDGES [0:17] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                                 -1048577, -1048576, 1048574, 1048575, 1048576, 0, 31, 32, -1};
  int          m_ptr;
  logic [31:0] m_wq[$];
  bit          m_pend_last, m_in_done, m_err;
  int          m_code, m_eaddr;
  logic [31:0] m_sum;
  bit          exp_we, exp_done;
  int          exp_addr;
  logic [31:0] exp_data;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  function automatic void refEncode(input int cls, input int f3, input int f7, input int rd,
                                    input int rs1, input int rs2, input int imm,
                                    output int nw, output logic [31:0] w0,
                                    output logic [31:0] w1, output bit bad, output int code);
    int op;
    nw = 1; w0 = 0; w1 = 0; bad = 0; code = 0;
    if (cls > 10) begin bad = 1; code = 3; return; end
    op = OPS[cls];
    case (cls)
      CLS_LW, CLS_I, CLS_JALR:
        if (cls == CLS_I && (f3 == 1 || f3 == 5)) begin
          bad = (imm < 0 || imm > 31);
          w0 = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        end else begin
          bad = (imm < -2048 || imm > 2047);
          w0 = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        end
      CLS_SW: begin
        bad = (imm < -2048 || imm > 2047);
        w0 = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
             ((imm & 31) << 7) | op;
      end
      CLS_B: begin
        bad  = (imm % 2 != 0) || imm < -4096 || imm > 4094;
        code = (imm % 2 != 0) ? 1 : 0;
        w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) |
             (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | op;
      end
      CLS_JAL: begin
        bad  = (imm % 2 != 0) || imm < -1048576 || imm > 1048574;
        code = (imm % 2 != 0) ? 1 : 0;
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | op;
      end
      CLS_LUI, CLS_AUIPC: w0 = ((imm & 'hFFFFF) << 12) | (rd << 7) | op;
      CLS_R, CLS_F: w0 = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      default: begin
        if (imm >= -2048 && imm <= 2047) begin
          w0 = ((imm & 'hFFF) << 20) | (rd << 7) | 'h13;
        end else begin
          nw = 2;
          w0 = ((((imm + 'h800) >> 12) & 'hFFFFF) << 12) | (rd << 7) | 'h37;
          w1 = ((imm & 'hFFF) << 20) | (rd << 15) | (rd << 7) | 'h13;
        end
      end
    endcase
  endfunction

  function automatic void modelClear();
    m_ptr = BASE; m_wq.delete(); m_pend_last = 0; m_in_done = 0;
    m_err = 0; m_code = 0; m_eaddr = 0; m_sum = 0;
  endfunction

  function automatic void modelError(input int code);
    if (!m_err) begin m_code = code; m_eaddr = m_ptr % DEPTH; end
    m_err = 1;
  endfunction

  function automatic void modelWrite(input logic [31:0] w);
    if (m_ptr >= DEPTH) begin
      modelError(2); m_in_done = 1; m_wq.delete();
    end else begin
      exp_we = 1; exp_addr = m_ptr; exp_data = w; m_ptr++; m_sum += w;
    end
  endfunction

  // Advances one clock: predicts the edge from current inputs, then compares.
  task automatic applyStimulus();
    int nw, code;
    logic [31:0] w0, w1;
    bit bad, nxt_done;
    #1;
    checkOutput("in_ready", in_ready, rst_n && !start && m_wq.size() == 0 && !m_in_done);
    exp_we   = 0;
    nxt_done = m_in_done && rst_n && !start;
    if (!rst_n || start) begin
      modelClear();
    end else if (m_wq.size() != 0) begin
      modelWrite(m_wq.pop_front());
      if (!m_in_done && m_wq.size() == 0 && m_pend_last) m_in_done = 1;
    end else if (in_valid && !m_in_done) begin
      refEncode(in_class, in_fun3, in_fun7, in_rd, in_rs1, in_rs2, in_imm, nw, w0, w1, bad, code);
      if (bad) begin
        modelError(code);
        if (in_last) m_in_done = 1;
      end else begin
        modelWrite(w0);
        if (!m_in_done && nw == 2) begin m_wq.push_back(w1); m_pend_last = in_last; end
        else if (in_last) m_in_done = 1;
      end
    end
    exp_done = nxt_done;
    @(posedge clk);
    #1;
    checkOutput("out_we", out_we, exp_we);
    if (exp_we) begin
      checkOutput("out_addr", out_addr, exp_addr);
      checkOutput("out_data", out_data, exp_data);
    end
    checkOutput("done", done, exp_done);
    checkOutput("err", err, m_err);
    checkOutput("err_code", err_code, m_code);
    checkOutput("err_addr", err_addr, m_eaddr);
`ifdef ENC_INSTR_CHECKSUM_EN
    checkOutput("checksum", checksum, m_sum);
`endif
  endtask

  task automatic setReq(input int cls, input int f3, input int f7, input int rd, input int rs1,
                        input int rs2, input int imm, input bit last);
    in_valid = 1; in_class = 4'(cls); in_fun3 = 3'(f3); in_fun7 = 7'(f7);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm; in_last = last;
  endtask

  task automatic idleCycle();
    in_valid = 0; in_last = 0;
    applyStimulus();
  endtask

  task automatic pulseStart();
    start = 1; in_valid = 0;
    applyStimulus();
    start = 0;
  endtask

  function automatic int randImm();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 40));
      1:       return int'($urandom_range(0, 8191)) - 4096;
      2:       return EDGES[$urandom_range(0, 17)];
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    modelClear();
    exp_we = 0; exp_done = 0; exp_addr = 0; exp_data = 0;
    @(negedge clk);
    rst_n = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_addr", out_addr, BASE);
    checkOutput("rst_data", out_data, 0);
    rst_n = 1;
    idleCycle();

    setReq(CLS_I, 0, 0, 1, 0, 0, 5, 0);
    applyStimulus();
    checkOutput("addi_data", out_data, 32'h00500093);
    checkOutput("addi_addr", out_addr, 0);
    idleCycle();

    pulseStart();
    setReq(CLS_LW, 2, 0, 2, 1, 0, 8, 0);
    applyStimulus();
    checkOutput("lw_data", out_data, 32'h0080A103);
    setReq(CLS_R, 0, 7'b0100000, 3, 1, 2, 0, 0);
    applyStimulus();
    checkOutput("sub_data", out_data, 32'h402081B3);
    checkOutput("sub_addr", out_addr, 1);
    idleCycle();

    pulseStart();
    setReq(CLS_LI, 0, 0, 5, 0, 0, 32'h12345FFF, 0);
    applyStimulus();
    checkOutput("li_hi", out_data, 32'h123462B7);
    setReq(CLS_I, 0, 0, 7, 0, 0, 1, 0);
    applyStimulus();
    checkOutput("li_lo", out_data, 32'hFFF28293);
    checkOutput("li_lo_addr", out_addr, 1);
    idleCycle();

    pulseStart();
    setReq(CLS_B, 0, 0, 0, 1, 2, 3, 0);
    applyStimulus();
    checkOutput("b_align_code", err_code, 1);
    setReq(CLS_I, 0, 0, 1, 0, 0, 5, 0);
    applyStimulus();
    checkOutput("after_err_addr", out_addr, 0);
    idleCycle();

    pulseStart();
    for (int i = 0; i <= DEPTH; i++) begin
      setReq(CLS_I, 0, 0, 1, 0, 0, i, 0);
      applyStimulus();
    end
    idleCycle();
    checkOutput("ovf_done", done, 1);
    checkOutput("ovf_code", err_code, 2);
    pulseStart();
    checkOutput("restart_err", err, 0);
    setReq(CLS_I, 0, 0, 1, 0, 0, 9, 1);
    applyStimulus();
    checkOutput("restart_addr", out_addr, 0);
    idleCycle();
    checkOutput("last_done", done, 1);

    start = 1;
    setReq(CLS_I, 0, 0, 1, 0, 0, 5, 0);
    applyStimulus();
    start = 0;
    checkOutput("start_we", out_we, 0);
    setReq(CLS_LI, 0, 0, 6, 0, 0, 32'h7ABCD123, 0);
    applyStimulus();
    rst_n = 0; in_valid = 0;
    applyStimulus();
    rst_n = 1;
    idleCycle();
    checkOutput("rst_li2_we", out_we, 0);

    for (int c = 0; c < 2500; c++) begin
      int cls;
      cls = ($urandom_range(0, 9) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
      setReq(cls, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), randImm(), $urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 39) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      applyStimulus();
    end
    start = 0; rst_n = 1;
    idleCycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
